// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, 1 or 2 stop bits, integer clock divisor.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        state    <= START;
                        baud_cnt <= CNT_LOAD;
                        shreg    <= tx_data;
                        par_bit  <= (^tx_data) ^ PAR_ODD;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        state    <= DATA;
                        baud_cnt <= CNT_LOAD;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    // tx is registered, so the next bit is taken from shreg[1] as the shift happens
                    if (baud_cnt == '0) begin
                        baud_cnt <= CNT_LOAD;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                PAR: begin
                    if (baud_cnt == '0) begin
                        state    <= STOP;
                        baud_cnt <= CNT_LOAD;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == '0) begin
                        if (bit_cnt == LAST_STOP) begin
                            state    <= IDLE;
                            tx       <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            baud_cnt <= CNT_LOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four configurations at CLKS_PER_BIT=4,
// expected line bit sequences queued by the stimulus and checked by a monitor.
module tb_uart_tx_cfg;

    localparam int CPB = 4;

    typedef struct {
        logic [11:0] bits;
        int          nb;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] data_r;
    logic [1:0] sel;
    logic       mon_en;

    logic [3:0] ready_v, tx_v, busy_v, done_v;
    logic       ready_m, tx_m, busy_m, done_m;

    exp_t exp_q[$];
    int   starts[$];
    int   cyc;
    int   vectors;
    int   miscompares;
    int   frames_pushed;
    int   frames_done;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && sel == 2'd0), .tx_data(data_r),
        .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_8e1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && sel == 2'd1), .tx_data(data_r),
        .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && sel == 2'd2), .tx_data(data_r),
        .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid && sel == 2'd3), .tx_data(data_r[6:0]),
        .tx_ready(ready_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    assign ready_m = ready_v[sel];
    assign tx_m    = tx_v[sel];
    assign busy_m  = busy_v[sel];
    assign done_m  = done_v[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: a falling tx while enabled marks a start bit; the whole frame is checked
    // cycle by cycle against the oldest queued expectation.
    always begin
        @(negedge clk);
        if (mon_en && !rst && tx_m == 1'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame: start bit seen at cycle %0d, required none", cyc);
                for (int k = 0; k < 200 && tx_m == 1'b0; k++) @(negedge clk);
            end else begin
                exp_t e;
                bit   bad_bits;
                bit   bad_busy;
                int   len;
                e        = exp_q.pop_front();
                len      = CPB * e.nb;
                bad_bits = 1'b0;
                bad_busy = 1'b0;
                starts.push_back(cyc);
                for (int j = 0; j < len; j++) begin
                    if (j > 0) @(negedge clk);
                    if (tx_m !== e.bits[j / CPB]) bad_bits = 1'b1;
                    if (busy_m !== 1'b1 || done_m !== 1'b0) bad_busy = 1'b1;
                end
                @(negedge clk);
                chk("frame_bits", int'(bad_bits), 0);
                chk("busy_during_frame", int'(bad_busy), 0);
                chk("done_ready_at_end", int'({done_m, ready_m, busy_m}), 3'b110);
                frames_done++;
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic [7:0] d, input logic [11:0] b,
                        input int nb, input bit push, input bit hold);
        int n;
        if (push) begin
            exp_q.push_back('{bits: b, nb: nb});
            frames_pushed++;
        end
        sel      = s;
        data_r   = d;
        tx_valid = 1'b1;
        n        = 0;
        while (!ready_m && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready_m) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: tx_ready=%0b after %0d cycles, required 1", ready_m, n);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && frames_done != frames_pushed; i++) @(negedge clk);
        chk(name, frames_done, frames_pushed);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int dcount;
        cyc           = 0;
        vectors       = 0;
        miscompares   = 0;
        frames_pushed = 0;
        frames_done   = 0;
        rst           = 1'b1;
        tx_valid      = 1'b0;
        data_r        = 8'h00;
        sel           = 2'd0;
        mon_en        = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx_m), 1);
        chk("reset_ready", int'(ready_m), 1);
        chk("reset_busy", int'(busy_m), 0);
        chk("reset_done", int'(done_m), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0x41: 0,1,0,0,0,0,0,1,0,1
        send(2'd0, 8'h41, 12'b1010000010, 10, 1, 0);
        drain("drain_8n1");
        // parity: even 0x41 -> 0, odd 0x41 -> 1, odd 0x00 -> 1
        send(2'd1, 8'h41, 12'b10010000010, 11, 1, 0);
        drain("drain_even41");
        send(2'd2, 8'h41, 12'b11010000010, 11, 1, 0);
        drain("drain_odd41");
        send(2'd2, 8'h00, 12'b11000000000, 11, 1, 0);
        drain("drain_odd00");
        // 7N2 0x55: 0,1,0,1,0,1,0,1,1,1
        send(2'd3, 8'h55, 12'b1110101010, 10, 1, 0);
        drain("drain_7n2");

        // back-to-back 0xA5 then 0x3C with tx_valid held
        send(2'd0, 8'hA5, 12'b1101001010, 10, 1, 1);
        send(2'd0, 8'h3C, 12'b1001111000, 10, 1, 0);
        drain("drain_b2b");
        chk("b2b_start_spacing", starts[starts.size()-1] - starts[starts.size()-2], 41);

        // reset during the third data bit abandons the frame
        mon_en = 1'b0;
        send(2'd0, 8'h41, 12'b0, 10, 0, 0);
        repeat (13) @(negedge clk);
        chk("busy_before_reset", int'(busy_m), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_tx", int'(tx_m), 1);
        chk("midreset_ready", int'(ready_m), 1);
        chk("midreset_busy", int'(busy_m), 0);
        chk("midreset_done", int'(done_m), 0);
        rst    = 1'b0;
        dcount = 0;
        repeat (50) begin
            @(negedge clk);
            if (done_m) dcount++;
        end
        chk("no_done_after_reset", dcount, 0);
        mon_en = 1'b1;
        send(2'd0, 8'h41, 12'b1010000010, 10, 1, 0);
        drain("drain_after_reset");

        // data changes and tx_valid toggles while busy must not disturb the frame
        send(2'd0, 8'h41, 12'b1010000010, 10, 1, 0);
        repeat (5) @(negedge clk);
        data_r   = 8'hFF;
        tx_valid = 1'b1;
        repeat (6) @(negedge clk);
        tx_valid = 1'b0;
        data_r   = 8'h00;
        repeat (4) @(negedge clk);
        tx_valid = 1'b1;
        repeat (6) @(negedge clk);
        tx_valid = 1'b0;
        drain("drain_ignore_busy");
        repeat (60) @(negedge clk);
        chk("no_extra_frame", frames_done, frames_pushed);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
